// File: rtl/riscv_irq_ctrl_if.sv
// Trap request handshake between the interrupt controller and the CSR unit.
// The controller drives request, cause and EPC; the CSR unit returns the accept.
interface riscv_irq_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned XLEN       = 64
);
    logic                  o_trap_req;
    logic [XLEN-1:0]       o_trap_cause;
    logic [ADDR_WIDTH-1:0] o_trap_epc;
    logic                  i_trap_ack;

    // Interrupt controller side
    modport master (
        output o_trap_req,
        output o_trap_cause,
        output o_trap_epc,
        input  i_trap_ack
    );

    // CSR unit side
    modport slave (
        input  o_trap_req,
        input  o_trap_cause,
        input  o_trap_epc,
        output i_trap_ack
    );
endinterface

// File: rtl/riscv_irq_ctrl.sv
// Machine-mode interrupt controller: latches MEIP/MTIP/MSIP, qualifies them with
// the global and per-source enables, waits for a commit boundary and raises one
// trap request with a prioritised cause (MEI > MSI > MTI) and EPC.
// Build option: define IRQ_CTRL_EXT_EN to let i_ext_irq take part; otherwise the
// port is ignored and o_mip[2] stays 0.
module riscv_irq_ctrl #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned XLEN       = 64,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clint_timer_irq,
    input  logic                  i_clint_sw_irq,
    input  logic                  i_ext_irq,
    input  logic                  i_mstatus_mie,
    input  logic                  i_mie_mtie,
    input  logic                  i_mie_msie,
    input  logic                  i_mie_meie,
    input  logic                  i_commit_valid,
    input  logic [ADDR_WIDTH-1:0] i_commit_next_pc,
    riscv_irq_ctrl_if.master      trap,
    output logic                  o_core_ready,
    output logic [2:0]            o_mip,
    output logic [CNT_WIDTH-1:0]  o_irq_cnt
);

    localparam logic [XLEN-1:0] CauseMei = {1'b1, {(XLEN-5){1'b0}}, 4'd11};
    localparam logic [XLEN-1:0] CauseMsi = {1'b1, {(XLEN-5){1'b0}}, 4'd3};
    localparam logic [XLEN-1:0] CauseMti = {1'b1, {(XLEN-5){1'b0}}, 4'd7};
    localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StIdle,
        StWaitCommit,
        StReq,
        StHold
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            mip_q, mip_d;
    logic [XLEN-1:0]       cause_q, cause_d;
    logic [ADDR_WIDTH-1:0] epc_q, epc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  ext_src;
    logic [2:0]            pend;
    logic                  fire;
    logic [XLEN-1:0]       prio_cause;

`ifdef IRQ_CTRL_EXT_EN
    assign ext_src = i_ext_irq;
`else
    // External source disabled in this build; the port is kept but ignored.
    logic unused_ext_irq;
    assign unused_ext_irq = i_ext_irq;
    assign ext_src        = 1'b0;
`endif

    assign mip_d = {ext_src, i_clint_timer_irq, i_clint_sw_irq};
    assign pend  = mip_q & {i_mie_meie, i_mie_mtie, i_mie_msie};
    assign fire  = i_mstatus_mie & (|pend);

    // Highest-priority enabled pending source, MEI > MSI > MTI
    always_comb begin
        prio_cause = CauseMti;
        if (pend[2]) begin
            prio_cause = CauseMei;
        end else if (pend[0]) begin
            prio_cause = CauseMsi;
        end
    end

    // Next-state logic; cause/EPC only change on the commit that enters StReq
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fire) begin
                    state_d = StWaitCommit;
                end
            end
            StWaitCommit: begin
                // Losing fire beats a same-cycle commit
                if (!fire) begin
                    state_d = StIdle;
                end else if (i_commit_valid) begin
                    state_d = StReq;
                    cause_d = prio_cause;
                    epc_d   = i_commit_next_pc;
                end
            end
            StReq: begin
                if (trap.i_trap_ack) begin
                    state_d = StHold;
                    cnt_d   = cnt_q + CntOne;
                    // Only a timer trap acknowledges the CLINT
                    ready_d = (cause_q == CauseMti);
                end
            end
            StHold: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            mip_q   <= 3'b000;
            cause_q <= '0;
            epc_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mip_q   <= mip_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign trap.o_trap_req   = (state_q == StReq);
    assign trap.o_trap_cause = cause_q;
    assign trap.o_trap_epc   = epc_q;
    assign o_core_ready      = ready_q;
    assign o_mip             = mip_q;
    assign o_irq_cnt         = cnt_q;

endmodule

// File: tb/tb_riscv_irq_ctrl.sv
// Self-checking bench for riscv_irq_ctrl: directed scenarios followed by random
// stimulus, all compared every cycle against a transaction-level model.
module tb_riscv_irq_ctrl;

    localparam int unsigned AW = 64;
    localparam int unsigned XL = 64;
    localparam int unsigned CW = 4;
    localparam logic [63:0] C_MEI = 64'h8000_0000_0000_000B;
    localparam logic [63:0] C_MSI = 64'h8000_0000_0000_0003;
    localparam logic [63:0] C_MTI = 64'h8000_0000_0000_0007;
`ifdef IRQ_CTRL_EXT_EN
    localparam bit EXT_EN = 1'b1;
    localparam logic [63:0] C_ALL = C_MEI;
`else
    localparam bit EXT_EN = 1'b0;
    localparam logic [63:0] C_ALL = C_MSI;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          timer = 1'b0, sw = 1'b0, ext = 1'b0;
    logic          mie = 1'b0, mtie = 1'b0, msie = 1'b0, meie = 1'b0;
    logic          commit = 1'b0;
    logic [AW-1:0] next_pc = '0;
    logic          ack = 1'b0;
    logic          core_ready;
    logic [2:0]    mip;
    logic [CW-1:0] irq_cnt;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model state
    logic [2:0]  m_mip   = 3'b000;
    bit          m_armed = 1'b0;
    bit          m_req   = 1'b0;
    bit          m_hold  = 1'b0;
    logic [63:0] m_cause = '0;
    logic [63:0] m_epc   = '0;
    bit          m_ready = 1'b0;
    int unsigned m_cnt   = 0;

    riscv_irq_ctrl_if #(.ADDR_WIDTH(AW), .XLEN(XL)) trap_if ();
    assign trap_if.i_trap_ack = ack;

    riscv_irq_ctrl #(.ADDR_WIDTH(AW), .XLEN(XL), .CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_clint_timer_irq(timer),
        .i_clint_sw_irq   (sw),
        .i_ext_irq        (ext),
        .i_mstatus_mie    (mie),
        .i_mie_mtie       (mtie),
        .i_mie_msie       (msie),
        .i_mie_meie       (meie),
        .i_commit_valid   (commit),
        .i_commit_next_pc (next_pc),
        .trap             (trap_if),
        .o_core_ready     (core_ready),
        .o_mip            (mip),
        .o_irq_cnt        (irq_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] model_cause(input logic [2:0] p);
        if (p[2]) return C_MEI;
        if (p[0]) return C_MSI;
        return C_MTI;
    endfunction

    // Advance the model by one clock using the inputs the DUT just sampled
    task automatic model_step();
        logic [2:0] pend;
        bit         fire;
        pend    = m_mip & {meie, mtie, msie};
        fire    = mie && (pend != 3'b000);
        m_ready = 1'b0;
        if (rst) begin
            m_mip = 3'b000; m_armed = 0; m_req = 0; m_hold = 0;
            m_cause = '0; m_epc = '0; m_cnt = 0;
        end else begin
            if (m_req) begin
                if (ack) begin
                    m_req   = 0;
                    m_hold  = 1;
                    m_cnt   = (m_cnt + 1) % (1 << CW);
                    m_ready = (m_cause == C_MTI);
                end
            end else if (m_hold) begin
                m_hold = 0;
            end else if (m_armed) begin
                if (!fire) m_armed = 0;
                else if (commit) begin
                    m_armed = 0;
                    m_req   = 1;
                    m_cause = model_cause(pend);
                    m_epc   = next_pc;
                end
            end else if (fire) begin
                m_armed = 1;
            end
            m_mip = {ext & EXT_EN, timer, sw};
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("trap_req", {63'd0, trap_if.o_trap_req}, {63'd0, m_req});
        check_eq("trap_cause", trap_if.o_trap_cause, m_cause);
        check_eq("trap_epc", trap_if.o_trap_epc, m_epc);
        check_eq("core_ready", {63'd0, core_ready}, {63'd0, m_ready});
        check_eq("mip", {61'd0, mip}, {61'd0, m_mip});
        check_eq("irq_cnt", {60'd0, irq_cnt}, 64'(m_cnt));
    endtask

    task automatic wait_req(input int max_cycles);
        int n = 0;
        while (!trap_if.o_trap_req && n < max_cycles) begin
            tick();
            n++;
        end
        check_eq("req_seen", {63'd0, trap_if.o_trap_req}, 64'd1);
    endtask

    task automatic drain();
        timer = 0; sw = 0; ext = 0; commit = 0; ack = 1;
        repeat (4) tick();
        ack = 0;
        repeat (2) tick();
    endtask

    initial begin
        repeat (2) tick();
        rst = 0;
        tick();
        check_eq("reset_req", {63'd0, trap_if.o_trap_req}, 64'd0);
        check_eq("reset_cnt", {60'd0, irq_cnt}, 64'd0);

        // Timer only
        mie = 1; mtie = 1; timer = 1; commit = 1; next_pc = 64'h8000_0010;
        wait_req(10);
        check_eq("tmr_cause", trap_if.o_trap_cause, C_MTI);
        check_eq("tmr_epc", trap_if.o_trap_epc, 64'h8000_0010);
        ack = 1; timer = 0;
        tick();
        ack = 0;
        check_eq("tmr_ready", {63'd0, core_ready}, 64'd1);
        check_eq("tmr_cnt", {60'd0, irq_cnt}, 64'd1);
        check_eq("tmr_req_low", {63'd0, trap_if.o_trap_req}, 64'd0);
        tick();
        check_eq("tmr_ready_once", {63'd0, core_ready}, 64'd0);
        drain();

        // All sources simultaneously
        msie = 1; meie = 1; timer = 1; sw = 1; ext = 1; commit = 1; next_pc = 64'h40;
        wait_req(10);
        check_eq("all_cause", trap_if.o_trap_cause, C_ALL);
        ack = 1;
        tick();
        ack = 0;
        check_eq("all_no_ready", {63'd0, core_ready}, 64'd0);
        drain();

        // Global disable
        msie = 0; meie = 0; mie = 0; timer = 1; commit = 1;
        repeat (50) begin
            tick();
            check_eq("gdis_req", {63'd0, trap_if.o_trap_req}, 64'd0);
        end
        mie = 1;
        wait_req(10);
        drain();

        // Abort: drop MTIE in WAIT_COMMIT, together with a commit
        commit = 0; timer = 1;
        repeat (2) tick();
        mtie = 0; commit = 1;
        repeat (5) begin
            tick();
            check_eq("abort_req", {63'd0, trap_if.o_trap_req}, 64'd0);
        end
        drain();

        // REQ hold with churning inputs
        mtie = 1; timer = 1; commit = 1; next_pc = 64'h1234;
        wait_req(10);
        repeat (10) begin
            {timer, sw, ext} = 3'($urandom);
            {mie, mtie, msie, meie, commit} = 5'($urandom);
            next_pc = {$urandom, $urandom};
            tick();
            check_eq("hold_req", {63'd0, trap_if.o_trap_req}, 64'd1);
            check_eq("hold_cause", trap_if.o_trap_cause, C_MTI);
            check_eq("hold_epc", trap_if.o_trap_epc, 64'h1234);
        end
        ack = 1;
        tick();
        ack = 0;
        check_eq("hold_req_drop", {63'd0, trap_if.o_trap_req}, 64'd0);
        drain();

        // Reset in REQ, with ack offered in the same cycle
        mie = 1; mtie = 1; msie = 0; meie = 0; timer = 1; commit = 1;
        wait_req(10);
        rst = 1; ack = 1;
        tick();
        rst = 0; ack = 0;
        check_eq("rst_req", {63'd0, trap_if.o_trap_req}, 64'd0);
        check_eq("rst_cause", trap_if.o_trap_cause, 64'd0);
        check_eq("rst_epc", trap_if.o_trap_epc, 64'd0);
        check_eq("rst_ready", {63'd0, core_ready}, 64'd0);
        check_eq("rst_mip", {61'd0, mip}, 64'd0);
        check_eq("rst_cnt", {60'd0, irq_cnt}, 64'd0);

        // Counter wrap: 16 traps on a 4-bit counter
        repeat (16) begin
            wait_req(10);
            ack = 1;
            tick();
            ack = 0;
        end
        check_eq("cnt_wrap", {60'd0, irq_cnt}, 64'd0);
        drain();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) timer = ~timer;
            if ($urandom_range(0, 7) == 0) sw = ~sw;
            if ($urandom_range(0, 7) == 0) ext = ~ext;
            mie     = ($urandom_range(0, 9) != 0);
            mtie    = ($urandom_range(0, 5) != 0);
            msie    = ($urandom_range(0, 5) != 0);
            meie    = ($urandom_range(0, 5) != 0);
            commit  = $urandom_range(0, 1) == 1;
            next_pc = {$urandom, $urandom};
            ack     = ($urandom_range(0, 2) == 0);
            rst     = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
